// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: divide-stall FSM state encoding and
// the width of its stall counter.
package pipe_pkg;

  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_stall_fsm.sv
// Multi-cycle divide stall sequencer: holds the pipeline for DIV_CYCLES cycles
// starting on the cycle a divide is seen in ID/EX, then flags one release cycle.
module div_stall_fsm
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic div_req,
  output logic div_stall,
  output logic div_done
);

  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;

  // The trigger cycle itself stalls, so BUSY only needs DIV_CYCLES-1 cycles.
  localparam logic [DIV_CNT_W-1:0] CNT_LOAD = DIV_CNT_W'(DIV_CYCLES - 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_req) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - DIV_CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign div_stall = ((state == IDLE) && div_req) || (state == BUSY);
  assign div_done  = (state == DONE);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: divide stall, load-use stall and taken-branch flush,
// resolved combinationally in that priority order.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_Uses_Rt,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic       ID_EX_Div,
  input  logic       Branch_Taken,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_Flush,
  output logic       ID_EX_Bubble,
  output logic       EX_Hold,
  output logic       Div_Busy,
  output logic       Div_Done
);

  logic div_stall;
  logic load_use;

  div_stall_fsm #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_fsm (
    .clk      (clk),
    .rst      (rst),
    .div_req  (ID_EX_Div),
    .div_stall(div_stall),
    .div_done (Div_Done)
  );

  // $0 is hardwired, so a load targeting it never produces a dependency.
  assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == ID_Rs) || (ID_Uses_Rt && (ID_EX_Rt == ID_Rt)));

  always_comb begin
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_Flush     = 1'b0;
    ID_EX_Bubble = 1'b0;
    EX_Hold      = 1'b0;
    Div_Busy     = 1'b0;
    if (div_stall) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      EX_Hold     = 1'b1;
      Div_Busy    = 1'b1;
    end else if (load_use) begin
      // A pending branch is dropped here and re-presented next cycle.
      PC_Write     = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (Branch_Taken) begin
      IF_Flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scoreboard bench for hazard_unit with DIV_CYCLES=32.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_Uses_Rt;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_Rt;
  logic       ID_EX_Div;
  logic       Branch_Taken;
  logic       PC_Write;
  logic       IF_ID_Write;
  logic       IF_Flush;
  logic       ID_EX_Bubble;
  logic       EX_Hold;
  logic       Div_Busy;
  logic       Div_Done;

  hazard_unit #(
    .DIV_CYCLES(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_Rs        (ID_Rs),
    .ID_Rt        (ID_Rt),
    .ID_Uses_Rt   (ID_Uses_Rt),
    .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_Rt     (ID_EX_Rt),
    .ID_EX_Div    (ID_EX_Div),
    .Branch_Taken (Branch_Taken),
    .PC_Write     (PC_Write),
    .IF_ID_Write  (IF_ID_Write),
    .IF_Flush     (IF_Flush),
    .ID_EX_Bubble (ID_EX_Bubble),
    .EX_Hold      (EX_Hold),
    .Div_Busy     (Div_Busy),
    .Div_Done     (Div_Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_Hold, Div_Busy, Div_Done}
  localparam logic [6:0] E_NORM   = 7'b1100000;
  localparam logic [6:0] E_LU     = 7'b0001000;
  localparam logic [6:0] E_FLUSH  = 7'b1110000;
  localparam logic [6:0] E_DIV    = 7'b0000110;
  localparam logic [6:0] E_DONE   = 7'b1100001;
  localparam logic [6:0] E_DONEFL = 7'b1110001;

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         drive_done = 1'b0;

  task automatic step(input logic r, input logic mr, input logic [4:0] exrt,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic dv, input logic br, input logic [6:0] e,
                      input string nm);
    @(posedge clk);
    #1;
    rst           = r;
    ID_EX_MemRead = mr;
    ID_EX_Rt      = exrt;
    ID_Rs         = rs;
    ID_Rt         = rt;
    ID_Uses_Rt    = urt;
    ID_EX_Div     = dv;
    Branch_Taken  = br;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are combinational, so each queued vector is checked mid-cycle.
  always @(negedge clk) begin
    logic [6:0] act;
    logic [6:0] e;
    string      nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {PC_Write, IF_ID_Write, IF_Flush, ID_EX_Bubble, EX_Hold, Div_Busy, Div_Done};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b", nm, act, e);
      end
    end
  end

  initial begin
    rst = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_Uses_Rt = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_Rt = '0; ID_EX_Div = 1'b0; Branch_Taken = 1'b0;

    // Reset and release
    step(0, 0, 0, 0, 0, 0, 0, 0, E_NORM, "reset_idle");
    step(0, 0, 0, 0, 0, 0, 0, 0, E_NORM, "reset_idle2");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM, "post_reset");

    // Load-use on rs, then recovery
    step(1, 1, 5, 5, 0, 0, 0, 0, E_LU,   "lu_rs");
    step(1, 0, 5, 5, 0, 0, 0, 0, E_NORM, "lu_release");
    // Load-use on rt only when rt is a source
    step(1, 1, 7, 3, 7, 1, 0, 0, E_LU,   "lu_rt_used");
    step(1, 1, 7, 3, 7, 0, 0, 0, E_NORM, "lu_rt_unused");
    // Register 0 never hazards
    step(1, 1, 0, 0, 0, 1, 0, 0, E_NORM, "lu_r0");
    step(1, 1, 5, 1, 5, 0, 0, 0, E_NORM, "rt5_not_used");
    step(1, 0, 5, 5, 5, 1, 0, 0, E_NORM, "not_load");

    // Branch alone, then branch deferred behind load-use
    step(1, 0, 0, 0, 0, 0, 0, 1, E_FLUSH, "branch");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM,  "branch_after");
    step(1, 1, 9, 9, 0, 0, 0, 1, E_LU,    "branch_lu_wins");
    step(1, 0, 9, 9, 0, 0, 0, 1, E_FLUSH, "branch_deferred");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM,  "branch_done");

    // Divide: 32 stall cycles with branch and load-use held, flush only in DONE
    step(1, 1, 4, 4, 0, 0, 1, 1, E_DIV, "div_trigger");
    for (int i = 1; i < 32; i++) step(1, 0, 0, 0, 0, 0, 1, 1, E_DIV, "div_stall");
    step(1, 0, 0, 0, 0, 0, 1, 1, E_DONEFL, "div_done_flush");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM,   "div_after");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM,   "div_after2");

    // Back-to-back divides with one release cycle between
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 0, 1, 0, E_DIV, "b2b_stall1");
    step(1, 0, 0, 0, 0, 0, 1, 0, E_DONE, "b2b_done1");
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 0, 1, 0, E_DIV, "b2b_stall2");
    step(1, 0, 0, 0, 0, 0, 1, 0, E_DONE, "b2b_done2");
    // Load-use still applies in the DONE cycle's successor
    step(1, 1, 6, 6, 0, 0, 0, 0, E_LU,   "b2b_after_lu");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM, "b2b_after");

    // Reset in BUSY at count 10: trigger plus 20 BUSY cycles (counts 30..11)
    for (int i = 0; i < 21; i++) step(1, 0, 0, 0, 0, 0, 1, 0, E_DIV, "rst_busy_stall");
    step(0, 0, 0, 0, 0, 0, 0, 0, E_NORM, "rst_in_busy");
    for (int i = 0; i < 14; i++) step(1, 0, 0, 0, 0, 0, 0, 0, E_NORM, "rst_after_busy");

    drive_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(drive_done && exp_q.size() == 0) && budget < 2000) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (!drive_done || exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: pending %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
